float_multiplier: RTL and testbench
===================================

# float_multiplier

Sequential IEEE-754 single-precision multiplier built as the inverse companion of the team's iterative `divider`, sharing its operand/result/start conventions. It checks divider quotients by re-multiplying (quotient × divisor ≈ dividend) and serves as the multiply unit of the FP datapath. A shift-add datapath performs one partial product per cycle. Operation is round-to-nearest-even with flush-to-zero.

## Interface
Parameters:
- `MUL_ITER`, default 24: shift-add iterations, equal to the significand width including the hidden bit. Fixed; not for override.

Ports:
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: asynchronous active-low reset.
- `input_a`  input  32: operand A, fp32.
- `input_b`  input  32: operand B, fp32.
- `start`  input  1: request.
  - Sampled only in IDLE.
  - Operands are captured on the same edge.
- `output_z`  output  32: product. Registered; holds its value until the next completion.
- `done`  output  1: one-cycle pulse marking that `output_z` is valid.
- `busy`  output  1: high from the accepting edge until the completing edge.

## Operation
- States: IDLE → UNPACK → MUL → NORM → ROUND → PACK → IDLE. The special path is UNPACK → PACK.
- IDLE: `start`=1 latches `input_a`/`input_b`; `busy`←1.
- UNPACK:
  - Split sign, exponent and fraction.
  - Classify each operand as zero, normal, inf or NaN. A denormal input (exp=0, frac≠0) is treated as zero.
  - Sign = sa^sb.
  - A special case loads its result and goes to PACK:
    - any NaN → 0x7FC00000;
    - inf×0 → 0x7FC00000;
    - inf×nonzero → {sign, 0xFF, 0};
    - zero×finite → {sign, 31'b0}.
  - Otherwise:
    - sum exponent = ea+eb−127, in 10-bit signed;
    - prepend the hidden bit to both 24-bit significands;
    - go to MUL.
- MUL: 48-bit accumulator.
  - Each cycle, if multiplier LSB=1, add the multiplicand, then shift.
  - Exactly `MUL_ITER` cycles, tracked by a 5-bit counter.
- NORM:
  - If product bit 47=1: take bits [46:24], exponent+1.
  - Else: take bits [45:23].
  - Guard = next lower bit; sticky = OR of all remaining bits.
- ROUND: RNE.
  - Increment when guard & (sticky | lsb).
  - Mantissa carry-out sets fraction 0 and increments the exponent.
- PACK:
  - Exponent ≥255 → {sign, 0xFF, 0} (overflow).
  - Exponent ≤0 → {sign, 31'b0} (FTZ underflow).
  - Else normal pack.
  - Register `output_z`, pulse `done`, clear `busy`, return to IDLE.
- `start` while `busy` is ignored; no queuing.
- `start` in the cycle `done` is high is accepted, because the state is IDLE.
- Operand changes after the accepting edge do not affect the result.

## Timing
- Reset values: `output_z`=0, `done`=0, `busy`=0, state=IDLE, counter=0.
- Reset is asynchronous. Asserting `rst` mid-operation aborts immediately with no `done`. The first `start` after release behaves normally.
- Accept edge is E0. Normal path:
  - UNPACK at E1;
  - MUL E2–E25;
  - NORM E26;
  - ROUND E27;
  - PACK E28: `done` high for the cycle after E28.
  - Latency is 28 cycles.
- Special path: PACK at E2, `done` after E2. Latency is 2 cycles.
- Back-to-back throughput: one result per 29 cycles (normal path).

## Structure
- Shared package `fp32_pkg`, also used by `divider`:
  - field widths (EXP_W=8, FRAC_W=23, BIAS=127);
  - canonical QNAN constant 0x7FC00000;
  - class enum {ZERO, NORMAL, INF, NAN};
  - state typedef.
- One natural sub-module, `fp32_round_pack`: combinational NORM/ROUND/PACK helper. Takes sign, exponent, and 48-bit product; produces the 32-bit result. Reusable by `divider`.
- Top level holds the FSM, the operand registers, and the shift-add datapath.

## Test plan
- 0x42E88000 (116.25) × 0x41780000 (15.5) → `output_z`=0x44E13C00 (1801.875). `done` exactly 28 cycles after the accepting edge; `busy` high throughout.
- 0x3F800001 × 0x40400000 (tie case, lsb=1) → 0x40400002; 0x40000000 × 0x40400000 → 0x40C00000.
- Special cases, each with `done` after 2 cycles:
  - 0x7F800000 × 0x00000000 → 0x7FC00000;
  - 0x3F800000 × 0x80000000 → 0x80000000;
  - 0xFF800000 × 0x40000000 → 0xFF800000.
- Overflow: 0x7F000000 × 0x40000000 → 0x7F800000. Underflow: 0x00800000 × 0x3F000000 → 0x00000000. Denormal input: 0x00000001 × 0x3F800000 → 0x00000000.
- Handshake:
  - `start` pulsed at cycle 10 of a running op is ignored; `output_z` reflects the first op only.
  - `start` held during the `done` cycle launches the next op; second `done` arrives 29 cycles after the first.
- Assert `rst` low at MUL iteration 12: `busy`/`done`/`output_z` go to 0 asynchronously with no `done` pulse. After release, 116.25 × 15.5 again → 0x44E13C00 at 28 cycles.

Source files
------------

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared IEEE-754 single-precision definitions for the FP datapath
// (float_multiplier, divider). Field widths, canonical quiet NaN, operand
// class, sequencer state encoding and an operand classifier.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MUL,
        S_NORM,
        S_ROUND,
        S_PACK
    } fp_state_t;

    // Denormals (exp=0, frac!=0) classify as ZERO: the datapath flushes to zero.
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        e = x[30:23];
        f = x[22:0];
        if (e == '0)
            return ZERO;
        else if (e == '1)
            return (f == '0) ? INF : NAN;
        else
            return NORMAL;
    endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: combinational normalise / round-to-nearest-even / pack.
// Ports:
//   sign    - result sign
//   exp_in  - 10-bit signed biased exponent before normalisation
//   prod    - 48-bit significand product (1.x * 1.x, so bit 47 or 46 is set)
//   result  - packed fp32, saturating to inf on overflow, flushing to zero
//             on underflow
import fp32_pkg::*;

module fp32_round_pack (
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [47:0]       prod,
    output logic [31:0]       result
);

    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;
    logic [22:0]       mant;
    logic [22:0]       frac;
    logic [23:0]       mant_r;
    logic              guard;
    logic              sticky;
    logic              inc;

    always_comb begin
        // Product in [1,4): bit 47 set means the value is >= 2, so shift one more.
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_in + 10'sd1;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            exp_n  = exp_in;
        end

        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {23'b0, inc};

        // Carry out of the 23-bit fraction means the significand reached 2.0.
        if (mant_r[23]) begin
            frac  = '0;
            exp_r = exp_n + 10'sd1;
        end else begin
            frac  = mant_r[22:0];
            exp_r = exp_n;
        end

        if (exp_r >= 10'sd255)
            result = {sign, 8'hFF, 23'b0};
        else if (exp_r <= 10'sd0)
            result = {sign, 31'b0};
        else
            result = {sign, exp_r[7:0], frac};
    end

endmodule

// File: rtl/float_multiplier.sv
// float_multiplier: sequential fp32 multiplier, RNE rounding, flush-to-zero.
// Shift-add significand multiply, one partial product per cycle.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   input_a, input_b  - fp32 operands, captured on the accepting edge
//   start             - request, sampled only in IDLE
//   output_z          - registered product, held until the next completion
//   done              - one-cycle pulse, output_z valid
//   busy              - high from accept edge to completion edge
// Normal path latency 28 cycles; special operands (zero/inf/NaN) 2 cycles.
import fp32_pkg::*;

module float_multiplier #(
    parameter int MUL_ITER = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        start,
    output logic [31:0] output_z,
    output logic        done,
    output logic        busy
);

    fp_state_t         state;
    logic [31:0]       a_q, b_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [23:0]       mcand;
    logic [47:0]       prod;
    logic [4:0]        cnt;
    logic [31:0]       res_q;

    fp_class_t         ca, cb;
    logic              s_ab;
    logic [24:0]       acc_sum;
    logic [31:0]       rp_result;

    assign ca      = fp_classify(a_q);
    assign cb      = fp_classify(b_q);
    assign s_ab    = a_q[31] ^ b_q[31];
    // Upper accumulator half plus multiplicand; carry feeds the shift-in bit.
    assign acc_sum = {1'b0, prod[47:24]} + {1'b0, mcand};

    fp32_round_pack u_round_pack (
        .sign   (sign_q),
        .exp_in (exp_q),
        .prod   (prod),
        .result (rp_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mcand    <= '0;
            prod     <= '0;
            cnt      <= '0;
            res_q    <= '0;
            output_z <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= input_a;
                        b_q   <= input_b;
                        busy  <= 1'b1;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_q <= s_ab;
                    if (ca == NAN || cb == NAN) begin
                        res_q <= QNAN;
                        state <= S_PACK;
                    end else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
                        res_q <= QNAN;
                        state <= S_PACK;
                    end else if (ca == INF || cb == INF) begin
                        res_q <= {s_ab, 8'hFF, 23'b0};
                        state <= S_PACK;
                    end else if (ca == ZERO || cb == ZERO) begin
                        res_q <= {s_ab, 31'b0};
                        state <= S_PACK;
                    end else begin
                        exp_q <= $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]})
                                 - 10'sd127;
                        mcand <= {1'b1, a_q[22:0]};
                        // Multiplier sits in the low half and shifts out as the
                        // product shifts in from the top.
                        prod  <= {24'b0, 1'b1, b_q[22:0]};
                        cnt   <= '0;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (prod[0])
                        prod <= {acc_sum, prod[23:1]};
                    else
                        prod <= {1'b0, prod[47:1]};
                    if (cnt == 5'(MUL_ITER - 1)) begin
                        cnt   <= '0;
                        state <= S_NORM;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                // Normalise/round are combinational in fp32_round_pack; these
                // two states give the product a settled cycle before capture,
                // keeping the same stage timing as the divider.
                S_NORM: begin
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    res_q <= rp_result;
                    state <= S_PACK;
                end
                S_PACK: begin
                    output_z <= res_q;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_multiplier.sv
module tb_float_multiplier;

    logic        clk;
    logic        rst;
    logic [31:0] input_a, input_b;
    logic        start;
    logic [31:0] output_z;
    logic        done;
    logic        busy;

    float_multiplier dut (
        .clk      (clk),
        .rst      (rst),
        .input_a  (input_a),
        .input_b  (input_b),
        .start    (start),
        .output_z (output_z),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, expv);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done act=%h exp=none", output_z);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("output_z", output_z, e.z);
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout act=%0d exp=0 pending", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd1 - 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] z, input int lat);
        @(negedge clk);
        input_a = a;
        input_b = b;
        start   = 1'b1;
        sb_q.push_back('{z: z, lat: lat, acc: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        chk("busy_run", 32'(busy), 32'd1);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("busy_run", 32'(busy), 32'd1);
        end
        drain();
    endtask

    localparam int NV = 10;
    logic [31:0] va [NV] = '{32'h42E88000, 32'h3F800001, 32'h40000000, 32'h7F800000,
                             32'h3F800000, 32'hFF800000, 32'h7F000000, 32'h00800000,
                             32'h00000001, 32'h7FC00001};
    logic [31:0] vb [NV] = '{32'h41780000, 32'h40400000, 32'h40400000, 32'h00000000,
                             32'h80000000, 32'h40000000, 32'h40000000, 32'h3F000000,
                             32'h3F800000, 32'h3F800000};
    logic [31:0] vz [NV] = '{32'h44E13C00, 32'h40400002, 32'h40C00000, 32'h7FC00000,
                             32'h80000000, 32'hFF800000, 32'h7F800000, 32'h00000000,
                             32'h00000000, 32'h7FC00000};
    int          vl [NV] = '{28, 28, 28, 2, 2, 2, 28, 28, 2, 2};

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        input_a = '0;
        input_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_output_z", output_z, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++)
            run_op(va[i], vb[i], vz[i], vl[i]);

        // start pulse mid-operation with new operands: ignored
        @(negedge clk);
        input_a = 32'h42E88000;
        input_b = 32'h41780000;
        start   = 1'b1;
        sb_q.push_back('{z: 32'h44E13C00, lat: 28, acc: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        input_a = 32'h40000000;
        input_b = 32'h40400000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (35) @(negedge clk);

        // start held through done: second op accepted on the edge after done
        @(negedge clk);
        input_a = 32'h42E88000;
        input_b = 32'h41780000;
        start   = 1'b1;
        sb_q.push_back('{z: 32'h44E13C00, lat: 28, acc: cyc + 1});
        sb_q.push_back('{z: 32'h40C00000, lat: 28, acc: cyc + 1 + 29});
        @(negedge clk);
        input_a = 32'h40000000;
        input_b = 32'h40400000;
        repeat (29) @(negedge clk);
        start = 1'b0;
        drain();

        // asynchronous reset at MUL iteration 12 aborts without done
        @(negedge clk);
        input_a = 32'h42E88000;
        input_b = 32'h41780000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_output_z", output_z, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        run_op(32'h42E88000, 32'h41780000, 32'h44E13C00, 28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
